// File: rtl/pipe_scheduler.sv
// -----------------------------------------------------------------------------
// pipe_scheduler
//
// Sequences the two-pipe obstacle datapath shared by the VGA renderer and the
// collision logic. It runs the IDLE / RUN / FROZEN game FSM, scrolls both pipes
// left on every game tick, launches pipe 2 one spacing behind pipe 1, respawns
// retired pipes at the right edge with an LFSR-chosen gap, and counts score as
// each pipe clears the bird column.
//
// Ports
//   clk          in   1   system clock
//   reset_n      in   1   synchronous active-low reset
//   tick         in   1   one-cycle game-update strobe (~95 Hz)
//   start        in   1   start/restart button level (rising edge used)
//   hit          in   1   collision flag from the core (level)
//   pipe1_x      out  10  pipe 1 left edge, hCount domain
//   pipe1_gap    out  10  pipe 1 gap top, vCount domain
//   pipe1_valid  out  1   pipe 1 drawn/collidable
//   pipe2_x      out  10  pipe 2 left edge
//   pipe2_gap    out  10  pipe 2 gap top
//   pipe2_valid  out  1   pipe 2 drawn/collidable
//   score        out  8   pipes cleared, saturating at 255
//   score_pulse  out  1   one-cycle strobe per scoring tick (fires at 255 too)
//   state        out  2   00 IDLE, 01 RUN, 10 FROZEN
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pipe_scheduler #(
    parameter int          X_MIN     = 144,
    parameter int          SPAWN_X   = 784,
    parameter int          SPACING   = 320,
    parameter int          PIPE_W    = 40,
    parameter int          BIRD_X    = 320,
    parameter int          SPEED     = 1,
    parameter int          GAP_MIN   = 60,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        start,
    input  logic        hit,
    output logic [9:0]  pipe1_x,
    output logic [9:0]  pipe1_gap,
    output logic        pipe1_valid,
    output logic [9:0]  pipe2_x,
    output logic [9:0]  pipe2_gap,
    output logic        pipe2_valid,
    output logic [7:0]  score,
    output logic        score_pulse,
    output logic [1:0]  state
);

    // Ten-bit versions of the geometry. SPAWN_X and X_MIN+SPEED stay below
    // 1024, so none of the x arithmetic below can wrap.
    localparam logic [9:0] SPAWN_X_C  = 10'(SPAWN_X);
    localparam logic [9:0] RETIRE_LIM = 10'(X_MIN + SPEED);
    localparam logic [9:0] SCORE_X_C  = 10'(BIRD_X - PIPE_W);
    localparam logic [9:0] LAUNCH_X   = 10'(SPAWN_X - SPACING);
    localparam logic [9:0] SPEED_C    = 10'(SPEED);
    localparam logic [9:0] GAP_MIN_C  = 10'(GAP_MIN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

    state_t      state_reg, state_next;

    logic [7:0]  lfsr_reg;
    logic        start_q_reg;
    logic [9:0]  x_reg     [2];
    logic [9:0]  gap_reg   [2];
    logic        valid_reg [2];
    logic [7:0]  score_reg;
    logic        score_pulse_reg;

    // FSM-issued datapath commands
    logic        do_start;
    logic        do_tick;

    logic        start_rise;
    logic        lfsr_fb;
    logic [9:0]  gap_new;

    // Per-pipe tick results
    logic        retire  [2];
    logic [9:0]  moved_x [2];
    logic        crossed [2];

    logic        launch;
    logic [8:0]  score_sum;

    assign start_rise = start & ~start_q_reg;

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero).
    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    // Every spawn in a cycle (start entry, respawn of either pipe, pipe 2
    // launch) uses the same pre-shift LFSR value.
    assign gap_new = GAP_MIN_C + {2'b00, lfsr_reg};

    // -------------------------------------------------------------------------
    // Per-pipe move / retire / score-line crossing, evaluated in parallel
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pipe
            assign retire[gi]  = (x_reg[gi] < RETIRE_LIM);
            assign moved_x[gi] = retire[gi] ? SPAWN_X_C : (x_reg[gi] - SPEED_C);
            // A respawned pipe lands at SPAWN_X, far right of the score line,
            // so the crossing test needs no special case for retirement.
            assign crossed[gi] = valid_reg[gi]
                               && (x_reg[gi]   >  SCORE_X_C)
                               && (moved_x[gi] <= SCORE_X_C);
        end
    endgenerate

    // Pipe 2 launches once, when pipe 1 crosses the stagger line.
    assign launch = valid_reg[0] && !valid_reg[1]
                  && (x_reg[0]   >  LAUNCH_X)
                  && (moved_x[0] <= LAUNCH_X);

    assign score_sum = {1'b0, score_reg}
                     + {8'd0, crossed[0]}
                     + {8'd0, crossed[1]};

    // -------------------------------------------------------------------------
    // Game FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_start   = 1'b0;
        do_tick    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_FROZEN: begin
                if (start_rise) begin
                    state_next = ST_RUN;
                    do_start   = 1'b1;
                end
            end
            ST_RUN: begin
                // hit wins over a same-cycle tick: freeze without moving.
                if (hit) begin
                    state_next = ST_FROZEN;
                end else if (tick) begin
                    do_tick = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Free-running LFSR and start edge register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_reg    <= LFSR_SEED;
            start_q_reg <= 1'b0;
        end else begin
            lfsr_reg    <= {lfsr_reg[6:0], lfsr_fb};
            start_q_reg <= start;
        end
    end

    // -------------------------------------------------------------------------
    // Pipe datapath and score
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                x_reg[i]     <= SPAWN_X_C;
                gap_reg[i]   <= GAP_MIN_C;
                valid_reg[i] <= 1'b0;
            end
            score_reg       <= 8'd0;
            score_pulse_reg <= 1'b0;
        end else begin
            score_pulse_reg <= 1'b0;
            if (do_start) begin
                x_reg[0]     <= SPAWN_X_C;
                gap_reg[0]   <= gap_new;
                valid_reg[0] <= 1'b1;
                // Pipe 2 is parked until pipe 1 reaches the stagger line;
                // its gap is left as-is since it is not drawn.
                x_reg[1]     <= SPAWN_X_C;
                valid_reg[1] <= 1'b0;
                score_reg    <= 8'd0;
            end else if (do_tick) begin
                for (int i = 0; i < 2; i++) begin
                    if (valid_reg[i]) begin
                        x_reg[i] <= moved_x[i];
                        if (retire[i]) begin
                            gap_reg[i] <= gap_new;
                        end
                    end
                end
                if (launch) begin
                    valid_reg[1] <= 1'b1;
                    x_reg[1]     <= SPAWN_X_C;
                    gap_reg[1]   <= gap_new;
                end
                if (crossed[0] || crossed[1]) begin
                    score_reg       <= score_sum[8] ? 8'hFF : score_sum[7:0];
                    score_pulse_reg <= 1'b1;
                end
            end
        end
    end

    assign pipe1_x     = x_reg[0];
    assign pipe1_gap   = gap_reg[0];
    assign pipe1_valid = valid_reg[0];
    assign pipe2_x     = x_reg[1];
    assign pipe2_gap   = gap_reg[1];
    assign pipe2_valid = valid_reg[1];
    assign score       = score_reg;
    assign score_pulse = score_pulse_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_pipe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pipe_scheduler
//
// Two schedulers share one stimulus stream: one at SPEED=1 (the shipped game
// geometry) and one at SPEED=8 (reaches score saturation quickly). Each is
// followed by a cycle-level reference model of the game rules, and every
// output is compared after every clock edge. A few directed milestones are
// also checked against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        hit = 1'b0;

    logic [9:0]  p1x  [2];
    logic [9:0]  p1g  [2];
    logic        p1v  [2];
    logic [9:0]  p2x  [2];
    logic [9:0]  p2g  [2];
    logic        p2v  [2];
    logic [7:0]  scr  [2];
    logic        pls  [2];
    logic [1:0]  st   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_scheduler #(.SPEED(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .hit(hit),
        .pipe1_x(p1x[0]), .pipe1_gap(p1g[0]), .pipe1_valid(p1v[0]),
        .pipe2_x(p2x[0]), .pipe2_gap(p2g[0]), .pipe2_valid(p2v[0]),
        .score(scr[0]), .score_pulse(pls[0]), .state(st[0])
    );

    pipe_scheduler #(.SPEED(8)) u_fast (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .hit(hit),
        .pipe1_x(p1x[1]), .pipe1_gap(p1g[1]), .pipe1_valid(p1v[1]),
        .pipe2_x(p2x[1]), .pipe2_gap(p2g[1]), .pipe2_valid(p2v[1]),
        .score(scr[1]), .score_pulse(pls[1]), .state(st[1])
    );

    // ---------------- reference model (game rules, plain integers) ----------
    localparam int SPAWN = 784;
    localparam int XMIN  = 144;
    localparam int SCOREX = 320 - 40;
    localparam int LAUNCHX = 784 - 320;

    int m_state [2];          // 0 idle, 1 run, 2 frozen
    int m_x     [2][2];
    int m_gap   [2][2];
    int m_valid [2][2];
    int m_score [2];
    int m_pulse [2];
    int m_lfsr  [2];
    int m_sq    [2];

    function automatic int lfsr_step(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    task automatic model_step(input int m, input bit rn, input bit tk, input bit sb, input bit ht);
        int sp, g, n;
        int nx [2];
        bit rise, lau;
        sp = (m == 0) ? 1 : 8;
        if (!rn) begin
            m_state[m] = 0;
            for (int p = 0; p < 2; p++) begin
                m_x[m][p] = SPAWN; m_gap[m][p] = 60; m_valid[m][p] = 0;
            end
            m_score[m] = 0; m_pulse[m] = 0; m_lfsr[m] = 8'hA5; m_sq[m] = 0;
            return;
        end
        rise = sb && (m_sq[m] == 0);
        g = 60 + m_lfsr[m];
        m_pulse[m] = 0;
        if (m_state[m] != 1) begin
            if (rise) begin
                m_state[m] = 1; m_score[m] = 0;
                m_x[m][0] = SPAWN; m_gap[m][0] = g; m_valid[m][0] = 1;
                m_x[m][1] = SPAWN; m_valid[m][1] = 0;
            end
        end else if (ht) begin
            m_state[m] = 2;
        end else if (tk) begin
            n = 0;
            for (int p = 0; p < 2; p++) begin
                nx[p] = (m_x[m][p] < XMIN + sp) ? SPAWN : m_x[m][p] - sp;
                if (m_valid[m][p] != 0 && m_x[m][p] > SCOREX && nx[p] <= SCOREX) n++;
            end
            lau = (m_valid[m][1] == 0) && m_x[m][0] > LAUNCHX && nx[0] <= LAUNCHX;
            for (int p = 0; p < 2; p++) begin
                if (m_valid[m][p] != 0) begin
                    if (nx[p] == SPAWN) m_gap[m][p] = g;
                    m_x[m][p] = nx[p];
                end
            end
            if (lau) begin
                m_valid[m][1] = 1; m_x[m][1] = SPAWN; m_gap[m][1] = g;
            end
            if (n > 0) begin
                m_score[m] = (m_score[m] + n > 255) ? 255 : m_score[m] + n;
                m_pulse[m] = 1;
            end
        end
        m_sq[m] = sb;
        m_lfsr[m] = lfsr_step(m_lfsr[m]);
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("state[%0d]", m),   int'(st[m]),  m_state[m]);
            check($sformatf("pipe1_x[%0d]", m), int'(p1x[m]), m_x[m][0]);
            check($sformatf("pipe1_gap[%0d]", m), int'(p1g[m]), m_gap[m][0]);
            check($sformatf("pipe1_valid[%0d]", m), int'(p1v[m]), m_valid[m][0]);
            check($sformatf("pipe2_x[%0d]", m), int'(p2x[m]), m_x[m][1]);
            check($sformatf("pipe2_gap[%0d]", m), int'(p2g[m]), m_gap[m][1]);
            check($sformatf("pipe2_valid[%0d]", m), int'(p2v[m]), m_valid[m][1]);
            check($sformatf("score[%0d]", m),   int'(scr[m]), m_score[m]);
            check($sformatf("score_pulse[%0d]", m), int'(pls[m]), m_pulse[m]);
        end
    endtask

    // One clock: drive inputs, step both models at the edge, compare #1 later.
    task automatic cycle(input bit rn, input bit tk, input bit sb, input bit ht);
        reset_n = rn; tick = tk; start = sb; hit = ht;
        @(posedge clk);
        model_step(0, rn, tk, sb, ht);
        model_step(1, rn, tk, sb, ht);
        #1;
        compare_all();
    endtask

    int pulse_cnt;
    bit sb;

    initial begin
        // Test 1: reset, then a start edge
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("reset_state", int'(st[0]), 0);
        check("reset_pipe1_x", int'(p1x[0]), 784);
        check("reset_pipe1_gap", int'(p1g[0]), 60);
        check("reset_valid", int'(p1v[0]) + int'(p2v[0]), 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        $display("txn start: state=%0d pipe1_x=%0d", st[0], p1x[0]);
        check("start_state", int'(st[0]), 1);
        check("start_pipe1_x", int'(p1x[0]), 784);
        check("start_pipe2_valid", int'(p2v[0]), 0);

        // Tests 2/3: 504 ticks with random idle gaps, start held high
        pulse_cnt = 0;
        for (int k = 1; k <= 504; k++) begin
            cycle(1, 1, 1, 0);
            if (pls[0]) pulse_cnt++;
            if (k == 320) begin
                check("t320_pipe1_x", int'(p1x[0]), 464);
                check("t320_pipe2_valid", int'(p2v[0]), 1);
                check("t320_pipe2_x", int'(p2x[0]), 784);
            end
            repeat ($urandom_range(0, 2)) begin
                cycle(1, 0, 1, 0);
                if (pls[0]) pulse_cnt++;
            end
        end
        $display("txn 504 ticks: pipe1_x=%0d score=%0d", p1x[0], scr[0]);
        check("t504_pipe1_x", int'(p1x[0]), 280);
        check("t504_score", int'(scr[0]), 1);
        check("t504_pulse_cycles", pulse_cnt, 1);

        // Test 5: hit with tick freezes without moving; restart clears score
        cycle(1, 1, 0, 1);
        $display("txn hit: state=%0d pipe1_x=%0d", st[0], p1x[0]);
        check("hit_state", int'(st[0]), 2);
        check("hit_pipe1_x", int'(p1x[0]), 280);
        repeat (5) cycle(1, 1, 0, 1);
        check("frozen_pipe1_x", int'(p1x[0]), 280);
        cycle(1, 0, 1, 0);
        $display("txn restart: state=%0d score=%0d", st[0], scr[0]);
        check("restart_state", int'(st[0]), 1);
        check("restart_score", int'(scr[0]), 0);

        // Randomized play: ticks, rare hits, start toggles, rare resets
        sb = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            bit rn, tk, ht;
            rn = ($urandom_range(0, 999) != 0);
            tk = ($urandom_range(0, 1) == 1);
            ht = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) sb = ~sb;
            if (!rn || ht || (sb && !start))
                $display("txn random: reset_n=%0b hit=%0b start=%0b state=%0d", rn, ht, sb, st[0]);
            cycle(rn, tk, sb, ht);
        end

        // Saturation: long uninterrupted run, tick every cycle
        cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 0);
        for (int k = 0; k < 11000; k++) cycle(1, 1, 1, 0);
        $display("txn long run: fast score=%0d slow score=%0d", scr[1], scr[0]);
        check("sat_score", int'(scr[1]), 255);

        // Reset mid-run aborts the game on that edge
        cycle(0, 1, 1, 0);
        $display("txn reset mid-run: state=%0d", st[1]);
        check("midreset_state", int'(st[1]), 0);
        check("midreset_score", int'(scr[1]), 0);
        check("midreset_pipe1_x", int'(p1x[1]), 784);
        cycle(1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
